// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // One-hot decode of a channel select.
  function automatic logic [N_CH-1:0] sel_dec(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// One-entry register slot: EMPTY/FULL state plus a data register.
// A load and a drain may happen in the same cycle (slot stays FULL).
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              can_load
);

  slot_state_t       state_q;
  logic [DATA_W-1:0] data_q;

  // Occupancy FSM: load wins over drain, drain alone empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= SLOT_EMPTY;
    else if (load)  state_q <= SLOT_FULL;
    else if (drain) state_q <= SLOT_EMPTY;
  end

  // Payload register; keeps the last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (load) data_q <= load_data;
  end

  assign valid    = (state_q == SLOT_FULL);
  assign data     = data_q;
  assign can_load = !valid || drain;

endmodule

// File: rtl/demux1_4.sv
// Registered 1-to-4 stream demultiplexer with per-channel holding slots.
// Optional per-channel saturating beat counters: define DEMUX1_4_CNT_EN.
module demux1_4
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*CNT_W-1:0]  out_cnt
);

  logic [N_CH-1:0]             can_load;
  logic [N_CH-1:0]             load;
  logic [N_CH-1:0]             drain;
  logic [N_CH-1:0][DATA_W-1:0] data_w;
  logic                        accept;

  // Ready only depends on the selected slot; other slots never stall the input.
  assign in_ready = can_load[sel];
  assign accept   = in_valid && in_ready;
  assign load     = accept ? sel_dec(sel) : '0;
  assign drain    = out_valid & out_ready;
  assign out_data = data_w;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .drain     (drain[k]),
      .valid     (out_valid[k]),
      .data      (data_w[k]),
      .can_load  (can_load[k])
    );
  end

`ifdef DEMUX1_4_CNT_EN
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;

  // Count accepted beats per channel, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (load[k] && (cnt_q[k] != {CNT_W{1'b1}}))
          cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign out_cnt = cnt_q;
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1_4.sv
// Self-checking bench for demux1_4: channel-level reference model plus
// directed vectors with literal expectations.
module tb_demux1_4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    sel = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, in_ready2;
  logic [4*DW-1:0] out_data, out_data2;
  logic [3:0]    out_valid, out_valid2;
  logic [3:0]    out_ready = '0;
  logic [4*CW-1:0] out_cnt;
  logic [4*2-1:0]  out_cnt2;

  int errors = 0;
  int checks = 0;

  demux1_4 #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt)
  );

  // Narrow-counter instance for the saturation case.
  demux1_4 #(.DATA_W(DW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_cnt(out_cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: per channel "holding something?", its payload, its count.
  bit          m_full [4];
  logic [7:0]  m_dat  [4];
  int          m_cnt  [4];
  bit          chk_en = 1'b0;

  function automatic bit m_ready(input logic [1:0] s);
    return !m_full[s] || out_ready[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0; m_dat[k] = '0; m_cnt[k] = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && m_ready(sel);
      for (int k = 0; k < 4; k++)
        if (m_full[k] && out_ready[k]) m_full[k] = 0;
      if (acc) begin
        m_full[sel] = 1;
        m_dat[sel]  = in_data;
`ifdef DEMUX1_4_CNT_EN
        if (m_cnt[sel] < 65535) m_cnt[sel]++;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = m_full[k];
      check("model out_valid", 64'(out_valid), 64'(ev));
      check("model in_ready", 64'(in_ready), 64'(m_ready(sel)));
      for (int k = 0; k < 4; k++) begin
        if (m_full[k]) check($sformatf("model lane%0d data", k), 64'(out_data[k*DW +: DW]), 64'(m_dat[k]));
        check($sformatf("model lane%0d cnt", k), 64'(out_cnt[k*CW +: CW]), 64'(m_cnt[k]));
      end
    end
  end

  task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic v, input logic [3:0] r);
    sel = s; in_data = d; in_valid = v; out_ready = r;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset then idle
    do_reset();
    chk_en = 1'b1;
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst in_ready", 64'(in_ready), 64'h1);
    check("rst out_cnt", 64'(out_cnt), 64'h0);
    check("rst out_data", 64'(out_data), 64'h0);

    // Route to each channel
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 8'hA0 + 8'(k), 1'b1, 4'b1111);
      step();
      check($sformatf("route%0d valid", k), 64'(out_valid), 64'(4'b0001 << k));
      check($sformatf("route%0d data", k), 64'(out_data[k*DW +: DW]), 64'(8'hA0 + k));
    end
    drive(0, 0, 1'b0, 4'b1111);
    step();
    check("route idle valid", 64'(out_valid), 64'h0);

    // Back-pressure isolation
    drive(1, 8'h11, 1'b1, 4'b1101);
    step();
    check("bp first valid", 64'(out_valid), 64'b0010);
    drive(1, 8'h22, 1'b1, 4'b1101);
    #1 check("bp stalled in_ready", 64'(in_ready), 64'h0);
    step();
    check("bp held lane1", 64'(out_data[1*DW +: DW]), 64'h11);
    drive(2, 8'h33, 1'b1, 4'b1101);
    #1 check("bp other in_ready", 64'(in_ready), 64'h1);
    step();
    check("bp both valid", 64'(out_valid), 64'b0110);
    drive(1, 8'h22, 1'b1, 4'b1111);
    #1 check("bp passthru in_ready", 64'(in_ready), 64'h1);
    step();
    check("bp reload valid", 64'(out_valid), 64'b0010);
    check("bp reload lane1", 64'(out_data[1*DW +: DW]), 64'h22);
    drive(0, 0, 1'b0, 4'b1111);
    step();

    // Full throughput to channel 3
    for (int i = 0; i < 16; i++) begin
      drive(3, 8'(i), 1'b1, 4'b1000);
      #1 check("tp in_ready", 64'(in_ready), 64'h1);
      step();
      check("tp lane3", 64'(out_data[3*DW +: DW]), 64'(i));
      check("tp valid", 64'(out_valid), 64'b1000);
    end
    drive(0, 0, 1'b0, 4'b1000);
    step();
    check("tp drained", 64'(out_valid), 64'h0);

    // Reset mid-stream with channels 0 and 2 full
    drive(0, 8'h55, 1'b1, 4'b0000);
    step();
    drive(2, 8'h66, 1'b1, 4'b0000);
    step();
    drive(0, 0, 1'b0, 4'b0000);
    check("mid pre valid", 64'(out_valid), 64'b0101);
    #1 rst_n = 1'b0;
    #1 check("mid async valid", 64'(out_valid), 64'h0);
    check("mid async data", 64'(out_data), 64'h0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 4'b1111);
    repeat (3) step();
    check("mid no replay", 64'(out_valid), 64'h0);

    // Counters
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'(i), 1'b1, 4'b1111);
      step();
    end
    drive(0, 0, 1'b0, 4'b1111);
    step();
`ifdef DEMUX1_4_CNT_EN
    check("cnt lane0", 64'(out_cnt[0 +: CW]), 64'd5);
    check("cnt sat lane0", 64'(out_cnt2[0 +: 2]), 64'd3);
`else
    check("cnt lane0 off", 64'(out_cnt), 64'd0);
    check("cnt sat off", 64'(out_cnt2), 64'd0);
`endif
    check("cnt other lanes", 64'(out_cnt[CW +: 3*CW]), 64'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
